// File: rtl/mte_round_engine.sv
// Purpose: iterative keyed multi-round cipher; encrypts (sel=1) or decrypts (sel=0) one N-bit word per transaction.
// Latency: ROUNDS edges from accept to out_valid for a nonzero key; a zero key bypasses the rounds and is valid right after accept.
// Backpressure: result is held in DONE until out_ready; in_ready is low while busy, so a new word waits for the return to IDLE.
//
// Ports:
//   clock, reset_n        clock and asynchronous active-low reset
//   key, in_data, sel     transaction inputs, captured on the in_valid/in_ready edge
//   in_valid, in_ready    input handshake
//   out_data, out_valid   result and its valid flag, held until out_ready
//   out_ready             sink accepts the result
//   valid_key             the key behind the current result was nonzero
//   busy                  engine is in RUN or DONE
module mte_round_engine #(
  parameter int N      = 8,
  parameter int ROUNDS = 4,
  parameter int ROT    = 1
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic [N-1:0] key,
  input  logic [N-1:0] in_data,
  input  logic         sel,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [N-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         valid_key,
  output logic         busy
);

  localparam logic [N-1:0] N_W    = N'(N);
  localparam logic [N-1:0] ROT_W  = N'(ROT);
  localparam logic [N-1:0] LAST_W = N'(ROUNDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t       state;
  state_t       state_nxt;

  logic [N-1:0] key_q;
  logic [N-1:0] x_q;
  logic [N-1:0] rnd_q;
  logic         sel_q;

  logic [N-1:0] rk;
  logic [N-1:0] enc_x;
  logic [N-1:0] dec_x;
  logic [N-1:0] round_x;
  logic         last_round;

  // Rotate left by any amount; the doubled word makes the wrap-around fall
  // out of a single shift, and reducing mod N keeps round indices >= N legal.
  function automatic logic [N-1:0] rotl(input logic [N-1:0] v, input logic [N-1:0] s);
    logic [2*N-1:0] t;
    t = {v, v} << (s % N_W);
    return t[2*N-1:N];
  endfunction

  // Round key for the index held in the counter.
  assign rk = rotl(key_q, rnd_q) ^ rnd_q;

  // Encrypt: xor, rotate left, add. Decrypt undoes it: subtract, rotate
  // right (a left rotate by N-ROT), xor.
  assign enc_x   = rotl(x_q ^ rk, ROT_W) + rk;
  assign dec_x   = rotl(x_q - rk, N_W - ROT_W) ^ rk;
  assign round_x = sel_q ? enc_x : dec_x;

  // Encrypt walks the index upward from 0, decrypt downward from ROUNDS-1.
  assign last_round = sel_q ? (rnd_q == LAST_W) : (rnd_q == '0);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = (state != IDLE);
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_nxt = (key != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        if (last_round) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Datapath. out_data/valid_key are only written on the edge that enters
  // DONE, so they stay stable through backpressure and afterwards.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      key_q     <= '0;
      x_q       <= '0;
      rnd_q     <= '0;
      sel_q     <= 1'b0;
      out_data  <= '0;
      valid_key <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            key_q <= key;
            sel_q <= sel;
            x_q   <= in_data;
            rnd_q <= sel ? '0 : LAST_W;
            if (key == '0) begin
              out_data  <= in_data;
              valid_key <= 1'b0;
            end
          end
        end
        RUN: begin
          x_q <= round_x;
          if (last_round) begin
            out_data  <= round_x;
            valid_key <= 1'b1;
          end else if (sel_q) begin
            rnd_q <= rnd_q + 1'b1;
          end else begin
            rnd_q <= rnd_q - 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mte_round_engine.sv
// Purpose: directed bench for mte_round_engine at N=8/ROUNDS=4/ROT=1 plus a round-trip sweep at N=16/ROUNDS=7/ROT=3.
// Latency: expected out_valid ROUNDS edges after accept (zero key: already valid after the accept edge).
// Backpressure: out_ready is held low in DONE to confirm the result and in_ready stay frozen.
module tb_mte_round_engine;

  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  // 8-bit instance
  logic [7:0] key8, din8, od8;
  logic       sel8, iv8, ir8, ov8, or8, vk8, busy8;

  // 16-bit instance
  logic [15:0] key16, din16, od16;
  logic        sel16, iv16, ir16, ov16, or16, vk16, busy16;

  mte_round_engine #(.N(8), .ROUNDS(4), .ROT(1)) dut8 (
    .clock(clock), .reset_n(reset_n),
    .key(key8), .in_data(din8), .sel(sel8),
    .in_valid(iv8), .in_ready(ir8),
    .out_data(od8), .out_valid(ov8), .out_ready(or8),
    .valid_key(vk8), .busy(busy8)
  );

  mte_round_engine #(.N(16), .ROUNDS(7), .ROT(3)) dut16 (
    .clock(clock), .reset_n(reset_n),
    .key(key16), .in_data(din16), .sel(sel16),
    .in_valid(iv16), .in_ready(ir16),
    .out_data(od16), .out_valid(ov16), .out_ready(or16),
    .valid_key(vk16), .busy(busy16)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Present one word for a single cycle, then scramble the inputs so the
  // in-flight transaction must rely on its own captured copies.
  task automatic start8(input logic [7:0] k, input logic [7:0] d, input logic s);
    check("accept_rdy8", 32'(ir8), 1);
    key8 = k; din8 = d; sel8 = s; iv8 = 1'b1;
    tick();
    iv8 = 1'b0; key8 = ~k; din8 = ~d; sel8 = ~s;
  endtask

  task automatic wait8(output int lat);
    lat = 0;
    while (ov8 !== 1'b1 && lat < 64) begin
      tick();
      lat++;
    end
  endtask

  task automatic finish8();
    or8 = 1'b1;
    tick();
    or8 = 1'b0;
  endtask

  task automatic xact16(input logic [15:0] k, input logic [15:0] d, input logic s,
                        output logic [15:0] res, output int lat);
    check("accept_rdy16", 32'(ir16), 1);
    key16 = k; din16 = d; sel16 = s; iv16 = 1'b1;
    tick();
    iv16 = 1'b0; key16 = ~k; din16 = ~d;
    lat = 0;
    while (ov16 !== 1'b1 && lat < 64) begin
      tick();
      lat++;
    end
    res = od16;
    check("rt_vk16", 32'(vk16), 1);
    or16 = 1'b1;
    tick();
    or16 = 1'b0;
    check("rt_idle16", 32'(busy16), 0);
  endtask

  int          lat;
  int          changed;
  logic [15:0] x, k, c, p;

  initial begin
    reset_n = 1'b0;
    key8 = '0; din8 = '0; sel8 = 1'b0; iv8 = 1'b0; or8 = 1'b0;
    key16 = '0; din16 = '0; sel16 = 1'b0; iv16 = 1'b0; or16 = 1'b0;
    #22;
    // Reset state
    check("rst_in_ready", 32'(ir8), 1);
    check("rst_out_valid", 32'(ov8), 0);
    check("rst_out_data", 32'(od8), 0);
    check("rst_valid_key", 32'(vk8), 0);
    check("rst_busy", 32'(busy8), 0);
    check("rst_in_ready16", 32'(ir16), 1);
    reset_n = 1'b1;
    tick();

    // 1: encrypt 0xFF with key 0x13 -> 0xEC, 0xBE, 0x2F, 0x04
    start8(8'h13, 8'hFF, 1'b1);
    check("enc_busy", 32'(busy8), 1);
    check("enc_in_ready_low", 32'(ir8), 0);
    check("enc_no_early_valid", 32'(ov8), 0);
    wait8(lat);
    check("enc_latency", 32'(lat), 4);
    check("enc_data", 32'(od8), 32'h04);
    check("enc_valid_key", 32'(vk8), 1);
    finish8();
    check("enc_ret_ready", 32'(ir8), 1);
    check("enc_ret_valid", 32'(ov8), 0);
    check("enc_ret_busy", 32'(busy8), 0);

    // 2: decrypt 0x04 with key 0x13 -> 0xFF
    start8(8'h13, 8'h04, 1'b0);
    wait8(lat);
    check("dec_latency", 32'(lat), 4);
    check("dec_data", 32'(od8), 32'hFF);
    check("dec_valid_key", 32'(vk8), 1);
    finish8();

    // 3: zero key bypasses the rounds in both modes
    start8(8'h00, 8'h5A, 1'b1);
    check("zk_enc_valid", 32'(ov8), 1);
    check("zk_enc_data", 32'(od8), 32'h5A);
    check("zk_enc_valid_key", 32'(vk8), 0);
    check("zk_enc_busy", 32'(busy8), 1);
    finish8();
    start8(8'h00, 8'h5A, 1'b0);
    check("zk_dec_valid", 32'(ov8), 1);
    check("zk_dec_data", 32'(od8), 32'h5A);
    check("zk_dec_valid_key", 32'(vk8), 0);
    finish8();
    check("zk_ret_ready", 32'(ir8), 1);

    // 4: backpressure with noise on the input side
    start8(8'h13, 8'hFF, 1'b1);
    wait8(lat);
    check("bp_latency", 32'(lat), 4);
    for (int i = 0; i < 5; i++) begin
      iv8 = 1'b1; key8 = 8'($urandom); din8 = 8'($urandom); sel8 = ~sel8;
      tick();
      check("bp_hold_data", 32'(od8), 32'h04);
      check("bp_in_ready", 32'(ir8), 0);
      check("bp_out_valid", 32'(ov8), 1);
      check("bp_valid_key", 32'(vk8), 1);
    end
    iv8 = 1'b0;
    or8 = 1'b1;
    tick();
    or8 = 1'b0;
    check("bp_release_ready", 32'(ir8), 1);
    check("bp_release_valid", 32'(ov8), 0);
    check("bp_data_after", 32'(od8), 32'h04);

    // 5: asynchronous reset two cycles into RUN
    start8(8'h13, 8'hFF, 1'b1);
    tick();
    tick();
    #2;
    reset_n = 1'b0;
    #1;
    check("ar_in_ready", 32'(ir8), 1);
    check("ar_out_valid", 32'(ov8), 0);
    check("ar_out_data", 32'(od8), 0);
    check("ar_valid_key", 32'(vk8), 0);
    check("ar_busy", 32'(busy8), 0);
    #2;
    reset_n = 1'b1;
    tick();
    check("ar_no_stale_valid", 32'(ov8), 0);
    start8(8'h13, 8'hFF, 1'b1);
    wait8(lat);
    check("ar_enc_latency", 32'(lat), 4);
    check("ar_enc_data", 32'(od8), 32'h04);
    finish8();

    // 6: round trip at N=16, ROUNDS=7, ROT=3
    changed = 0;
    for (int i = 0; i < 200; i++) begin
      x = 16'($urandom);
      k = 16'($urandom);
      if (k == 16'h0000) k = 16'h0001;
      xact16(k, x, 1'b1, c, lat);
      check("rt_enc_latency", 32'(lat), 7);
      if (c != x) changed++;
      xact16(k, c, 1'b0, p, lat);
      check("rt_dec_latency", 32'(lat), 7);
      check("rt_plain", 32'(p), 32'(x));
    end
    // A working cipher leaves almost no word unchanged.
    check("rt_cipher_moves", 32'(changed >= 190), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
